imem_ctrl: RTL

- Parametrised, loadable instruction memory that supersedes the fixed 32-bit instruction ROM; sits between the fetch stage and the program loader.
- After reset it zero-fills its storage, accepts a program over a word-write load port, then serves fetches over a valid/ready request/response interface.
- Fetches have a registered one-cycle read latency, support backpressure and flag misaligned or out-of-range addresses.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_array.sv | 43 ++++
 rtl/imem_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
package imem_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        StClear,
        StLoad,
        StRun
    } state_e;

    // Full-width compare; callers zero-extend their address to 64 bits.
    function automatic logic addr_fault(input logic [63:0] addr, input int unsigned depth_words);
        logic [63:0] limit;
        limit = 64'(depth_words) << 2;
        return (addr[1:0] != 2'b00) || (addr >= limit);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Single-port synchronous RAM with one write port and a registered read.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned Depth = 128,
    localparam int unsigned Aw = $clog2(Depth)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [Aw-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [Depth];
    logic [WORD_W-1:0] rdata_d, rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_ctrl.sv
// Instruction memory controller: zero-fill, program load, then valid/ready fetch service.
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 128,
    parameter logic [31:0] FILL_WORD   = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              load_done,
    output logic              busy,
    output logic              load_err,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_fault,
    input  logic              resp_ready
);

    localparam int unsigned Aw = $clog2(DEPTH_WORDS);

    state_e            state_d, state_q;
    logic [Aw-1:0]     clr_cnt_d, clr_cnt_q;
    logic              resp_valid_d, resp_valid_q;
    logic              resp_fault_d, resp_fault_q;
    logic              load_err_d, load_err_q;

    logic              load_fault, req_fault, accept;
    logic              ram_we, ram_re;
    logic [Aw-1:0]     ram_addr;
    logic [WORD_W-1:0] ram_wdata, ram_rdata;

    assign load_fault = addr_fault(64'(load_addr), DEPTH_WORDS);
    assign req_fault  = addr_fault(64'(req_addr), DEPTH_WORDS);
    assign req_ready  = (state_q == StRun) && (!resp_valid_q || resp_ready);
    assign accept     = req_valid && req_ready;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        resp_valid_d = resp_valid_q;
        resp_fault_d = resp_fault_q;
        load_err_d   = load_err_q;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_addr     = req_addr[Aw+1:2];
        ram_wdata    = load_data;
        unique case (state_q)
            StClear: begin
                ram_we    = 1'b1;
                ram_addr  = clr_cnt_q;
                ram_wdata = FILL_WORD;
                clr_cnt_d = clr_cnt_q + Aw'(1);
                if (clr_cnt_q == Aw'(DEPTH_WORDS - 1)) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                ram_addr = load_addr[Aw+1:2];
                if (load_en) begin
                    if (load_fault) begin
                        load_err_d = 1'b1;
                    end else begin
                        ram_we = 1'b1;
                    end
                end
                if (load_done) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Faulting fetches skip the RAM; the fault flag masks the stale read data.
                if (accept) begin
                    resp_valid_d = 1'b1;
                    resp_fault_d = req_fault;
                    ram_re       = !req_fault;
                end else if (resp_ready) begin
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StClear;
            clr_cnt_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            load_err_q   <= load_err_d;
        end
    end

    imem_array #(
        .Depth(DEPTH_WORDS)
    ) u_array (
        .clk_i  (clock),
        .rst_ni (reset),
        .we_i   (ram_we),
        .re_i   (ram_re),
        .addr_i (ram_addr),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    assign busy       = (state_q != StRun);
    assign load_err   = load_err_q;
    assign resp_valid = resp_valid_q;
    assign resp_fault = resp_fault_q;
    assign resp_data  = resp_fault_q ? '0 : ram_rdata;

endmodule
